rle_spi_fetch: RTL

SPI flash read sequencer feeding the RLE video decoder. On each frame restart it deselects the flash and issues a standard 0x03 READ command with a 24-bit start address. It then streams 16-bit big-endian RLE words from the flash into a small FIFO, stalling the SPI clock whenever that FIFO is full. It sits between the SPI pins (CS on uio_out[0], MOSI on uio_out[1], MISO on uio_in[2], SCK on uio_out[3]) and the run-length decoder that drives the 6-bit VGA colour output.

---
 rtl/rle_spi_fetch.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rle_spi_fetch.sv
`default_nettype none
// ============================================================================
// Module   : rle_spi_fetch
// Purpose  : SPI flash read sequencer for the RLE video decoder. On every
//            frame_start it deselects the flash, sends a 0x03 READ command
//            with a 24-bit start address, then streams 16-bit big-endian
//            words into a small FIFO. SCK is parked low whenever the FIFO
//            has no room for another word.
// Ports    : clk, rst_n                - clock, async active-low reset
//            frame_start, start_addr   - restart request and flash address
//            spi_cs_n, spi_clk,
//            spi_mosi, spi_miso        - SPI mode-0 pins (SCK = clk/2)
//            out_data, out_valid,
//            out_ready                 - FIFO head towards the RLE decoder
//            busy                      - high outside IDLE
// Revision : 1.0 - initial release
// ============================================================================
module rle_spi_fetch #(
  parameter int         DEPTH        = 2,
  parameter logic [7:0] CMD          = 8'h03,
  parameter int         DESEL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [23:0] start_addr,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(DESEL_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DESEL   = 3'd1,
    CMDADDR = 3'd2,
    DATA    = 3'd3,
    STALL   = 3'd4
  } state_t;

  state_t state, state_next;

  logic           phase;      // 0 = SCK low phase, 1 = SCK high phase
  logic [4:0]     bit_cnt;
  logic [31:0]    tx_shift;
  logic [14:0]    rx_shift;   // first 15 bits of the word in flight
  logic [DCW-1:0] desel_cnt;

  logic [15:0]    mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count, count_next;

  logic pop, push, word_done, slot_ok;

  // --------------------------------------------------------------------------
  // Next-state logic. slot_ok looks at the count after this cycle's push and
  // pop, so a freed slot lets the next word start on the very same edge.
  // --------------------------------------------------------------------------
  always_comb begin
    pop        = out_valid && out_ready && !frame_start;
    word_done  = (state == DATA) && phase && (bit_cnt == 5'd15);
    push       = word_done && !frame_start;
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
    slot_ok    = (count_next < CW'(DEPTH));
    state_next = state;

    case (state)
      IDLE:    state_next = IDLE;
      DESEL:   if (desel_cnt == DCW'(DESEL_CYCLES - 1)) state_next = CMDADDR;
      CMDADDR: if (phase && (bit_cnt == 5'd31)) state_next = DATA;
      DATA:    if (word_done && !slot_ok) state_next = STALL;
      STALL:   if (slot_ok) state_next = DATA;
      default: state_next = IDLE;
    endcase

    if (frame_start) begin
      state_next = DESEL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Bit sequencing. Shift registers advance on the edge that ends a high
  // phase, so MOSI only ever changes at the start of a low phase and MISO is
  // sampled exactly where SCK falls.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      bit_cnt   <= 5'd0;
      tx_shift  <= 32'd0;
      rx_shift  <= 15'd0;
      desel_cnt <= '0;
    end else if (frame_start) begin
      phase     <= 1'b0;
      bit_cnt   <= 5'd0;
      tx_shift  <= {CMD, start_addr};
      desel_cnt <= '0;
    end else begin
      case (state)
        DESEL: begin
          desel_cnt <= desel_cnt + DCW'(1);
          phase     <= 1'b0;
          bit_cnt   <= 5'd0;
        end
        CMDADDR: begin
          phase <= ~phase;
          if (phase) begin
            tx_shift <= {tx_shift[30:0], 1'b0};
            bit_cnt  <= (bit_cnt == 5'd31) ? 5'd0 : bit_cnt + 5'd1;
          end
        end
        DATA: begin
          phase <= ~phase;
          if (phase) begin
            rx_shift <= {rx_shift[13:0], spi_miso};
            bit_cnt  <= (bit_cnt == 5'd15) ? 5'd0 : bit_cnt + 5'd1;
          end
        end
        default: begin
          phase   <= 1'b0;
          bit_cnt <= 5'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Word FIFO. frame_start flushes it and overrides any pop in that cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 16'd0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (frame_start) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {rx_shift, spi_miso};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  assign spi_cs_n  = (state == IDLE) || (state == DESEL);
  assign spi_clk   = phase && ((state == CMDADDR) || (state == DATA));
  assign spi_mosi  = (state == CMDADDR) && tx_shift[31];
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire
